// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the set-associative cache array and its controller:
//   - clog2()        : constant-safe ceiling log2 used to derive field widths
//   - *_DEF          : default geometry (28-bit word address, 256-bit lines,
//                      64 KiB, 2 ways -> 1024 sets, index [12:3], tag [27:13])
//   - cache_line_t   : one stored line {data, tag, dirty, valid}
//   - cache_state_e  : array life-cycle state (init sweep / ready)
// -----------------------------------------------------------------------------
package cache_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    localparam int ADDR_WIDTH_DEF   = 32'sd28;
    localparam int DATA_WIDTH_DEF   = 32'sd32;
    localparam int BLOCK_SIZE_DEF   = 32'sd256;
    localparam int CACHE_SIZE_DEF   = 32'sd65536;
    localparam int WAYS_DEF         = 32'sd2;
    localparam int OFFSET_WIDTH_DEF = clog2(BLOCK_SIZE_DEF / DATA_WIDTH_DEF);
    localparam int NUM_SETS_DEF     = CACHE_SIZE_DEF * 32'sd8 / BLOCK_SIZE_DEF / WAYS_DEF;
    localparam int INDEX_WIDTH_DEF  = clog2(NUM_SETS_DEF);
    localparam int TAG_WIDTH_DEF    = ADDR_WIDTH_DEF - INDEX_WIDTH_DEF - OFFSET_WIDTH_DEF;

    typedef struct packed {
        logic [BLOCK_SIZE_DEF-1:0] data;
        logic [TAG_WIDTH_DEF-1:0]  tag;
        logic                      dirty;
        logic                      valid;
    } cache_line_t;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } cache_state_e;

endpackage

// File: rtl/cache_plru.sv
// -----------------------------------------------------------------------------
// cache_plru
// Combinational tree pseudo-LRU helper for one set.
//   plru_i       : WAYS-1 tree bits of the set (heap order, node n at bit n-1;
//                  a bit value of 0 means the left subtree is least recently used)
//   valid_i      : per-way valid bits of the set
//   access_way_i : way being touched this cycle (hit way or fill target)
//   victim_way_o : lowest invalid way, else the way the tree points at
//   plru_o       : tree bits after marking access_way_i most recently used
// -----------------------------------------------------------------------------
module cache_plru
    import cache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int WAY_W  = 1,
    parameter int PLRU_W = 1
) (
    input  logic [PLRU_W-1:0] plru_i,
    input  logic [WAYS-1:0]   valid_i,
    input  logic [WAY_W-1:0]  access_way_i,
    output logic [WAY_W-1:0]  victim_way_o,
    output logic [PLRU_W-1:0] plru_o
);

    localparam int LEVELS = clog2(WAYS);

    // Victim choice: fill empty ways first, otherwise follow the LRU pointers down the tree.
    always_comb begin : p_victim
        int   node;
        logic found;
        node         = 32'sd1;
        found        = 1'b0;
        victim_way_o = '0;
        for (int w = 32'sd0; w < WAYS; w++) begin
            if (!valid_i[w] && !found) begin
                victim_way_o = WAY_W'(w);
                found        = 1'b1;
            end else begin
                found = found;
            end
        end
        if (!found) begin
            for (int l = 32'sd0; l < LEVELS; l++) begin
                node = 32'sd2 * node + int'(plru_i[node - 32'sd1]);
            end
            victim_way_o = WAY_W'(node - WAYS);
        end else begin
            node = node;
        end
    end

    // MRU update: every node on the path to the accessed leaf points away from it.
    always_comb begin : p_update
        int path;
        int node;
        int dir;
        plru_o = plru_i;
        node   = 32'sd0;
        dir    = 32'sd0;
        path   = int'(access_way_i) + WAYS;
        for (int l = 32'sd0; l < LEVELS; l++) begin
            node = path >>> (LEVELS - l);
            dir  = (path >>> (LEVELS - l - 32'sd1)) & 32'sd1;
            plru_o[node - 32'sd1] = (dir == 32'sd0);
        end
    end

endmodule

// File: rtl/cache_memory_assoc.sv
// -----------------------------------------------------------------------------
// cache_memory_assoc
// N-way set-associative tag/data/state array with pseudo-LRU replacement.
// After reset a sweep clears valid/dirty/PLRU of every set (req_ready low),
// then one request per cycle is accepted. Lookups and line writes are
// answered two edges later with read-first contents plus victim details.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_addr/write/data/dirty     word address, lookup(0)/write(1), line, dirty
//   resp_valid/hit/way/data/dirty response strobe and hit information
//   victim_valid/dirty/tag/data   replacement candidate on a miss
//   init_done                     set once the clear sweep completes
// -----------------------------------------------------------------------------
module cache_memory_assoc
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 256,
    parameter int CACHE_SIZE = 65536,
    parameter int WAYS       = 2,
    localparam int OFFSET_WIDTH = clog2(BLOCK_SIZE / DATA_WIDTH),
    localparam int NUM_SETS     = CACHE_SIZE * 8 / BLOCK_SIZE / WAYS,
    localparam int INDEX_WIDTH  = clog2(NUM_SETS),
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
    localparam int WAY_W        = (WAYS > 1) ? clog2(WAYS) : 1,
    localparam int PLRU_W       = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [BLOCK_SIZE-1:0] req_data,
    input  logic                  req_dirty,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [WAY_W-1:0]      resp_way,
    output logic [BLOCK_SIZE-1:0] resp_data,
    output logic                  resp_dirty,
    output logic                  victim_valid,
    output logic                  victim_dirty,
    output logic [TAG_WIDTH-1:0]  victim_tag,
    output logic [BLOCK_SIZE-1:0] victim_data,
    output logic                  init_done
);

    typedef struct packed {
        logic                  hit;
        logic [WAY_W-1:0]      way;
        logic [BLOCK_SIZE-1:0] data;
        logic                  dirty;
        logic                  vvalid;
        logic                  vdirty;
        logic [TAG_WIDTH-1:0]  vtag;
        logic [BLOCK_SIZE-1:0] vdata;
    } resp_t;

    // Storage: data and tags need no reset, state bits are cleared by the sweep.
    logic [BLOCK_SIZE-1:0] data_mem  [NUM_SETS][WAYS];
    logic [TAG_WIDTH-1:0]  tag_mem   [NUM_SETS][WAYS];
    logic [WAYS-1:0]       valid_mem [NUM_SETS];
    logic [WAYS-1:0]       dirty_mem [NUM_SETS];
    logic [PLRU_W-1:0]     plru_mem  [NUM_SETS];

    cache_state_e           state_q;
    logic [INDEX_WIDTH-1:0] cnt_q;
    logic                   ready_q;
    logic                   init_done_q;
    logic                   s1_valid_q;
    resp_t                  s1_q;
    logic                   resp_valid_q;
    resp_t                  resp_q;
    resp_t                  resp_d;

    logic [INDEX_WIDTH-1:0] set_s;
    logic [TAG_WIDTH-1:0]   tag_s;
    logic [WAYS-1:0]        hit_vec_s;
    logic                   hit_s;
    logic [WAY_W-1:0]       hit_way_s;
    logic [WAY_W-1:0]       victim_way_s;
    logic [WAY_W-1:0]       target_way_s;
    logic [PLRU_W-1:0]      plru_next_s;
    logic                   accept_s;

    assign set_s        = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign tag_s        = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign accept_s     = rst_n & ready_q & req_valid;
    assign hit_s        = |hit_vec_s;
    assign target_way_s = hit_s ? hit_way_s : victim_way_s;

    generate
        if (OFFSET_WIDTH > 0) begin : g_offset
            logic unused_offset_s;
            assign unused_offset_s = ^req_addr[OFFSET_WIDTH-1:0];
        end
    endgenerate

    // Tag compare across the ways of the addressed set; lowest matching way wins.
    always_comb begin
        hit_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec_s[w] = valid_mem[set_s][w] && (tag_mem[set_s][w] == tag_s);
            if (hit_vec_s[w]) begin
                hit_way_s = WAY_W'(w);
            end else begin
                hit_way_s = hit_way_s;
            end
        end
    end

    cache_plru #(
        .WAYS   (WAYS),
        .WAY_W  (WAY_W),
        .PLRU_W (PLRU_W)
    ) u_plru (
        .plru_i       (plru_mem[set_s]),
        .valid_i      (valid_mem[set_s]),
        .access_way_i (target_way_s),
        .victim_way_o (victim_way_s),
        .plru_o       (plru_next_s)
    );

    // Read-first response fields; victim details only on a miss and only from a valid line.
    always_comb begin
        resp_d     = '0;
        resp_d.hit = hit_s;
        resp_d.way = target_way_s;
        if (hit_s) begin
            resp_d.data  = data_mem[set_s][hit_way_s];
            resp_d.dirty = dirty_mem[set_s][hit_way_s];
        end else begin
            resp_d.vvalid = valid_mem[set_s][victim_way_s];
            if (valid_mem[set_s][victim_way_s]) begin
                resp_d.vdirty = dirty_mem[set_s][victim_way_s];
                resp_d.vtag   = tag_mem[set_s][victim_way_s];
                resp_d.vdata  = data_mem[set_s][victim_way_s];
            end else begin
                resp_d.vdirty = 1'b0;
            end
        end
    end

    // Array update: sweep clears one set per cycle, accepted writes store the line, hits/writes touch PLRU.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ST_INIT)) begin
            valid_mem[cnt_q] <= '0;
            dirty_mem[cnt_q] <= '0;
            plru_mem[cnt_q]  <= '0;
        end else if (accept_s) begin
            if (req_write) begin
                data_mem[set_s][target_way_s]  <= req_data;
                tag_mem[set_s][target_way_s]   <= tag_s;
                valid_mem[set_s][target_way_s] <= 1'b1;
                dirty_mem[set_s][target_way_s] <= req_dirty;
            end
            if (req_write || hit_s) begin
                plru_mem[set_s] <= plru_next_s;
            end
        end
    end

    // Control FSM plus the two response pipeline stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            init_done_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + INDEX_WIDTH'(1);
                    if (cnt_q == INDEX_WIDTH'(NUM_SETS - 1)) begin
                        state_q     <= ST_READY;
                        ready_q     <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
            s1_valid_q <= accept_s;
            if (accept_s) begin
                s1_q <= resp_d;
            end
            resp_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                resp_q <= s1_q;
            end
        end
    end

    assign req_ready    = ready_q;
    assign init_done    = init_done_q;
    assign resp_valid   = resp_valid_q;
    assign resp_hit     = resp_q.hit;
    assign resp_way     = resp_q.way;
    assign resp_data    = resp_q.data;
    assign resp_dirty   = resp_q.dirty;
    assign victim_valid = resp_q.vvalid;
    assign victim_dirty = resp_q.vdirty;
    assign victim_tag   = resp_q.vtag;
    assign victim_data  = resp_q.vdata;

endmodule
